apb_timer_slave: RTL and testbench

APB2 slave peripheral sitting directly downstream of the AHB-to-APB bridge, attached to one bit of the bridge's `Pselx` bus. It provides a memory-mapped down-counting timer: control, reload, current value and sticky-status registers, plus a level interrupt. All register accesses use the bridge's two-phase APB2 protocol (setup, then access; no `Pready`, no wait states).

---
 rtl/apb_timer_slave.sv | 160 ++++++++++++++++
 tb/tb_apb_timer_slave.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer_slave.sv
// APB2 down-counting timer slave: CTRL/LOAD/VALUE/STATUS registers and a level irq.
// Optional prescaler on a PRESC register, enabled by defining APB_TIMER_PRESCALE_EN.
module apb_timer_slave #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned PRESC_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Psel,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        irq
);

    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,
        REG_LOAD   = 3'd1,
        REG_VALUE  = 3'd2,
        REG_STATUS = 3'd3,
        REG_PRESC  = 3'd4
    } reg_e;

    logic [2:0]       addr;
    logic             setup_rd, wr_access;
    logic             wr_ctrl, wr_load, wr_status, wr_presc;
    logic             tick;
    logic [31:0]      rdata, presc_rd;

    logic             en_q, en_d;
    logic             auto_q, auto_d;
    logic             irqen_q, irqen_d;
    logic [WIDTH-1:0] load_q, load_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             expired_q, expired_d;
    logic [31:0]      prdata_q, prdata_d;
    logic             irq_q, irq_d;

    logic             unused_bits;

    assign addr      = Paddr[4:2];
    assign setup_rd  = Psel & ~Penable & ~Pwrite;
    assign wr_access = Psel & Penable & Pwrite;
    assign wr_ctrl   = wr_access && (addr == REG_CTRL);
    assign wr_load   = wr_access && (addr == REG_LOAD);
    assign wr_status = wr_access && (addr == REG_STATUS);
    assign wr_presc  = wr_access && (addr == REG_PRESC);

    assign unused_bits = ^{Paddr[31:5], Paddr[1:0], Pwdata};

`ifdef APB_TIMER_PRESCALE_EN
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic [PRESC_WIDTH-1:0] pcnt_q, pcnt_d;

    // pcnt wraps at PRESC; held at 0 while disabled or when PRESC is rewritten
    always_comb begin
        presc_d = presc_q;
        pcnt_d  = '0;
        if (wr_presc)
            presc_d = Pwdata[PRESC_WIDTH-1:0];
        if (en_q && !wr_presc && (pcnt_q != presc_q))
            pcnt_d = pcnt_q + PRESC_WIDTH'(1);
    end

    assign tick     = en_q && (pcnt_q == presc_q);
    assign presc_rd = 32'(presc_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            pcnt_q  <= '0;
        end else begin
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
        end
    end
`else
    logic unused_presc;
    assign unused_presc = wr_presc;
    assign tick         = en_q;
    assign presc_rd     = '0;
`endif

    // Register writes are applied after the tick so LOAD/CTRL writes win;
    // the STATUS clear is applied before the tick so a new expiry wins.
    always_comb begin
        en_d      = en_q;
        auto_d    = auto_q;
        irqen_d   = irqen_q;
        load_d    = load_q;
        value_d   = value_q;
        expired_d = expired_q & ~(wr_status & Pwdata[0]);

        if (tick) begin
            if (value_q != '0) begin
                value_d = value_q - WIDTH'(1);
            end else begin
                expired_d = 1'b1;
                if (auto_q)
                    value_d = load_q;
                else
                    en_d = 1'b0;
            end
        end

        if (wr_ctrl) begin
            en_d    = Pwdata[0];
            auto_d  = Pwdata[1];
            irqen_d = Pwdata[2];
        end

        if (wr_load) begin
            load_d  = Pwdata[WIDTH-1:0];
            value_d = Pwdata[WIDTH-1:0];
        end

        irq_d = expired_d & irqen_d;
    end

    always_comb begin
        rdata = '0;
        case (addr)
            REG_CTRL:   rdata = {29'd0, irqen_q, auto_q, en_q};
            REG_LOAD:   rdata = 32'(load_q);
            REG_VALUE:  rdata = 32'(value_q);
            REG_STATUS: rdata = {31'd0, expired_q};
            REG_PRESC:  rdata = presc_rd;
            default:    rdata = '0;
        endcase
        prdata_d = setup_rd ? rdata : prdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            irqen_q   <= 1'b0;
            load_q    <= '0;
            value_q   <= '0;
            expired_q <= 1'b0;
            prdata_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            en_q      <= en_d;
            auto_q    <= auto_d;
            irqen_q   <= irqen_d;
            load_q    <= load_d;
            value_q   <= value_d;
            expired_q <= expired_d;
            prdata_q  <= prdata_d;
            irq_q     <= irq_d;
        end
    end

    assign Prdata = prdata_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Self-checking bench for apb_timer_slave: randomized APB traffic against a closed-form timer model.
module tb_apb_timer_slave;

    localparam int unsigned WIDTH = 16;
    localparam logic [31:0] MASK  = 32'h0000_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Psel = 1'b0;
    logic        Penable = 1'b0;
    logic        Pwrite = 1'b0;
    logic [31:0] Paddr = '0;
    logic [31:0] Pwdata = '0;
    logic [31:0] Prdata;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    apb_timer_slave #(.WIDTH(WIDTH), .PRESC_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .Psel(Psel), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // All tasks start and end #1 after a rising edge; cyc then equals the edge count so far.
    task automatic do_reset();
        rst = 1'b1; Psel = 1'b0; Penable = 1'b0; Pwrite = 1'b0; Paddr = '0; Pwdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output int acc_edge);
        Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1;
        Paddr = ($urandom & 32'hFFFF_FFE3) | (a & 32'h0000_001C);
        Pwdata = d;
        @(posedge clk); #1 Penable = 1'b1;
        @(posedge clk); #1 acc_edge = cyc;
        Psel = 1'b0; Penable = 1'b0; Pwrite = 1'b0;
    endtask

    // setup_edge: Prdata reflects the state left by edge setup_edge-1
    task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output int setup_edge);
        Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b0;
        Paddr = ($urandom & 32'hFFFF_FFE3) | (a & 32'h0000_001C);
        @(posedge clk); #1 setup_edge = cyc;
        Penable = 1'b1;
        d = Prdata;
        @(posedge clk); #1 Psel = 1'b0; Penable = 1'b0;
    endtask

    // Closed-form model: k ticks after enabling with reload value L
    function automatic logic [31:0] m_auto_value(int L, int k);
        return 32'(L - (k % (L + 1)));
    endfunction

    function automatic logic [31:0] m_oneshot_value(int L, int k);
        return (k >= L) ? 32'd0 : 32'(L - k);
    endfunction

    task automatic test_reset();
        int e, s, L;
        logic [31:0] d;
        do_reset();
        L = $urandom_range(1, 4);
        apb_write(32'h04, 32'(L), e);
        apb_write(32'h00, 32'h7, e);
        repeat (12) @(posedge clk);
        #1;
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL reset_pre_irq got=%b exp=1", irq); end
        Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b0; Paddr = 32'h08; rst = 1'b1;
        @(posedge clk); #1 Penable = 1'b1;
        @(posedge clk); #1 rst = 1'b0; Psel = 1'b0; Penable = 1'b0;
        n_cmp++;
        if (Prdata !== 32'd0) begin n_err++; $display("FAIL reset_prdata got=%h exp=0", Prdata); end
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", irq); end
        for (int a = 0; a < 8; a++) begin
            apb_read(32'(a * 4), d, s);
            n_cmp++;
            if (d !== 32'd0) begin n_err++; $display("FAIL reset_reg%0d got=%h exp=0", a * 4, d); end
        end
    endtask

    task automatic test_regs();
        int e, s;
        logic [31:0] d, v, exp_p;
        do_reset();
        apb_write(32'h04, 32'h5, e);
        apb_read(32'h04, d, s);
        n_cmp++;
        if (d !== 32'h5) begin n_err++; $display("FAIL regs_load got=%h exp=5", d); end
        apb_read(32'h08, d, s);
        n_cmp++;
        if (d !== 32'h5) begin n_err++; $display("FAIL regs_value got=%h exp=5", d); end
        apb_write(32'h08, 32'h9, e);
        apb_read(32'h08, d, s);
        n_cmp++;
        if (d !== 32'h5) begin n_err++; $display("FAIL regs_value_ro got=%h exp=5", d); end
        apb_read(32'h18, d, s);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL regs_unmapped18 got=%h exp=0", d); end
        apb_write(32'h00, 32'hFFFF_FFF8, e);
        apb_read(32'h00, d, s);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL regs_ctrl_rsvd got=%h exp=0", d); end
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            apb_write(32'h04, v, e);
            apb_read(32'h04, d, s);
            n_cmp++;
            if (d !== (v & MASK)) begin n_err++; $display("FAIL regs_load_rand got=%h exp=%h", d, v & MASK); end
            apb_read(32'h08, d, s);
            n_cmp++;
            if (d !== (v & MASK)) begin n_err++; $display("FAIL regs_value_rand got=%h exp=%h", d, v & MASK); end
            apb_write(32'(32'h14 + 4 * $urandom_range(0, 2)), $urandom, e);
            apb_read(32'(32'h14 + 4 * $urandom_range(0, 2)), d, s);
            n_cmp++;
            if (d !== 32'h0) begin n_err++; $display("FAIL regs_unmapped got=%h exp=0", d); end
        end
        v = $urandom;
        apb_write(32'h10, v, e);
        apb_read(32'h10, d, s);
`ifdef APB_TIMER_PRESCALE_EN
        exp_p = v & 32'hFF;
`else
        exp_p = 32'h0;
`endif
        n_cmp++;
        if (d !== exp_p) begin n_err++; $display("FAIL regs_presc got=%h exp=%h", d, exp_p); end
    endtask

    task automatic test_auto_reload();
        int e0, w, s, L, kw, f, n;
        logic [31:0] d;
        logic exp_b;
        for (int it = 0; it < 2; it++) begin
            do_reset();
            L = (it == 0) ? 3 : $urandom_range(1, 6);
            apb_write(32'h04, 32'(L), e0);
            apb_write(32'h00, 32'h7, e0);
            for (int i = 0; i < 2 * (L + 1) + 2; i++) begin
                apb_read(32'h08, d, s);
                n_cmp++;
                if (d !== m_auto_value(L, s - 1 - e0)) begin
                    n_err++;
                    $display("FAIL auto_value L=%0d k=%0d got=%h exp=%h", L, s - 1 - e0, d, m_auto_value(L, s - 1 - e0));
                end
                exp_b = (cyc - e0) >= (L + 1);
                n_cmp++;
                if (irq !== exp_b) begin n_err++; $display("FAIL auto_irq L=%0d got=%b exp=%b", L, irq, exp_b); end
            end
            apb_read(32'h0C, d, s);
            n_cmp++;
            if (d !== 32'h1) begin n_err++; $display("FAIL auto_status got=%h exp=1", d); end
            apb_read(32'h00, d, s);
            n_cmp++;
            if (d !== 32'h7) begin n_err++; $display("FAIL auto_ctrl got=%h exp=7", d); end
            apb_write(32'h0C, 32'h1, w);
            kw = w - e0;
            f  = ((kw + L) / (L + 1)) * (L + 1);
            for (int j = 0; j <= 2 * (L + 1); j++) begin
                n = cyc - e0;
                exp_b = (f <= n);
                n_cmp++;
                if (irq !== exp_b) begin n_err++; $display("FAIL auto_w1c_irq L=%0d n=%0d got=%b exp=%b", L, n, irq, exp_b); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_one_shot();
        int e0, s, L, k;
        logic [31:0] d, exp_v;
        for (int it = 0; it < 2; it++) begin
            do_reset();
            L = (it == 0) ? 2 : $urandom_range(1, 5);
            apb_write(32'h04, 32'(L), e0);
            apb_write(32'h00, 32'h1, e0);
            for (int i = 0; i < 5; i++) begin
                apb_read(32'h08, d, s);
                k = s - 1 - e0;
                exp_v = m_oneshot_value(L, k);
                n_cmp++;
                if (d !== exp_v) begin n_err++; $display("FAIL oneshot_value L=%0d k=%0d got=%h exp=%h", L, k, d, exp_v); end
                apb_read(32'h00, d, s);
                k = s - 1 - e0;
                exp_v = (k >= L + 1) ? 32'h0 : 32'h1;
                n_cmp++;
                if (d !== exp_v) begin n_err++; $display("FAIL oneshot_ctrl L=%0d k=%0d got=%h exp=%h", L, k, d, exp_v); end
                apb_read(32'h0C, d, s);
                k = s - 1 - e0;
                exp_v = (k >= L + 1) ? 32'h1 : 32'h0;
                n_cmp++;
                if (d !== exp_v) begin n_err++; $display("FAIL oneshot_status L=%0d k=%0d got=%h exp=%h", L, k, d, exp_v); end
                n_cmp++;
                if (irq !== 1'b0) begin n_err++; $display("FAIL oneshot_irq got=%b exp=0", irq); end
            end
        end
    endtask

    task automatic test_collisions();
        int e0, w, s, L, N, t;
        logic [31:0] d, exp_v;
        // LOAD write on a tick edge
        do_reset();
        L = $urandom_range(3, 9);
        apb_write(32'h04, 32'(L), e0);
        apb_write(32'h00, 32'h3, e0);
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1;
        N = $urandom_range(100, 32'h7FFF);
        apb_write(32'h04, 32'(N), w);
        apb_read(32'h08, d, s);
        exp_v = 32'(N - (s - 1 - w));
        n_cmp++;
        if (d !== exp_v) begin n_err++; $display("FAIL coll_load_value got=%h exp=%h", d, exp_v); end
        apb_read(32'h04, d, s);
        n_cmp++;
        if (d !== 32'(N)) begin n_err++; $display("FAIL coll_load_reg got=%h exp=%h", d, 32'(N)); end

        // STATUS clear on an expiry edge
        do_reset();
        L = $urandom_range(1, 4);
        apb_write(32'h04, 32'(L), e0);
        apb_write(32'h00, 32'h7, e0);
        t = e0 + 3 * (L + 1);
        while (cyc < t - 2) begin @(posedge clk); #1; end
        apb_write(32'h0C, 32'h1, w);
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL coll_w1c_irq got=%b exp=1", irq); end
        apb_read(32'h0C, d, s);
        n_cmp++;
        if (d !== 32'h1) begin n_err++; $display("FAIL coll_w1c_status got=%h exp=1", d); end

        // CTRL write on the one-shot auto-clear edge
        do_reset();
        L = $urandom_range(1, 4);
        apb_write(32'h04, 32'(L), e0);
        apb_write(32'h00, 32'h1, e0);
        t = e0 + L + 1;
        while (cyc < t - 2) begin @(posedge clk); #1; end
        apb_write(32'h00, 32'h7, w);
        apb_read(32'h00, d, s);
        n_cmp++;
        if (d !== 32'h7) begin n_err++; $display("FAIL coll_ctrl got=%h exp=7", d); end
        apb_read(32'h0C, d, s);
        n_cmp++;
        if (d !== 32'h1) begin n_err++; $display("FAIL coll_ctrl_status got=%h exp=1", d); end
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL coll_ctrl_irq got=%b exp=1", irq); end

        // LOAD=0 with auto-reload expires every tick
        do_reset();
        apb_write(32'h04, 32'h0, e0);
        apb_write(32'h00, 32'h3, e0);
        repeat (3) @(posedge clk);
        #1;
        apb_write(32'h0C, 32'h1, w);
        apb_read(32'h0C, d, s);
        n_cmp++;
        if (d !== 32'h1) begin n_err++; $display("FAIL load0_status got=%h exp=1", d); end
        apb_read(32'h08, d, s);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL load0_value got=%h exp=0", d); end
    endtask

    task automatic test_presc();
        int e0, s, k;
        logic [31:0] d, exp_v;
        logic exp_b;
        do_reset();
`ifdef APB_TIMER_PRESCALE_EN
        apb_write(32'h10, 32'h2, e0);
        apb_write(32'h04, 32'h1, e0);
        apb_write(32'h00, 32'h7, e0);
        for (int j = 0; j < 9; j++) begin
            exp_b = (cyc - e0) >= 6;
            n_cmp++;
            if (irq !== exp_b) begin n_err++; $display("FAIL presc_irq n=%0d got=%b exp=%b", cyc - e0, irq, exp_b); end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 4; i++) begin
            apb_read(32'h08, d, s);
            k = (s - 1 - e0) / 3;
            exp_v = m_auto_value(1, k);
            n_cmp++;
            if (d !== exp_v) begin n_err++; $display("FAIL presc_value got=%h exp=%h", d, exp_v); end
        end
`else
        apb_write(32'h04, 32'h4, e0);
        apb_write(32'h00, 32'h3, e0);
        for (int i = 0; i < 2; i++) begin
            apb_read(32'h08, d, s);
            exp_v = m_auto_value(4, s - 1 - e0);
            n_cmp++;
            if (d !== exp_v) begin n_err++; $display("FAIL tick_value got=%h exp=%h", d, exp_v); end
        end
`endif
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_regs();
        test_auto_reload();
        test_one_shot();
        test_collisions();
        test_presc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
